regfile_wb_sched: RTL and testbench
===================================

REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 Parameter DW, default 64: width of register data.
REQ-002 Parameter NREG, default 15: number of architectural registers (addresses 0..NREG-1).
REQ-003 Parameter RNONE, default 4'hF: register ID meaning "no write".
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  reset, active low.
REQ-005 wb_valid  input  1  writeback request from the write-back stage.
REQ-006 wb_ready  output  1  block can accept a request this cycle.
REQ-007 dstE  input  4  destination register for valE.
REQ-008 valE  input  DW  ALU result.
REQ-009 dstM  input  4  destination register for valM.
REQ-010 valM  input  DW  memory read result.
REQ-011 rf_we  output  1  register file write enable for the single write port.
REQ-012 rf_waddr  output  4  register file write address.
REQ-013 rf_wdata  output  DW  register file write data.
REQ-014 pend_mask  output  NREG  bit i set means a write to register i is accepted but not yet issued; used by decode to stall.
REQ-015 wb_done  output  1  one-cycle pulse when an accepted request is fully retired.
REQ-016 wr_count  output  16  saturating count of issued rf writes.

Function
REQ-017 The block SHALL implement a state machine with states IDLE, WR_E and WR_M.
REQ-018 wb_ready SHALL be 1 only in IDLE; a request is accepted on a rising edge with wb_valid=1 and wb_ready=1, latching dstE, valE, dstM and valM.
REQ-019 On accept, the next state SHALL be WR_E if dstE is not RNONE and dstE differs from dstM; else WR_M if dstM is not RNONE; else IDLE.
REQ-020 In WR_E, rf_we=1, rf_waddr=latched dstE and rf_wdata=latched valE; the next state SHALL be WR_M if latched dstM is not RNONE, else IDLE.
REQ-021 In WR_M, rf_we=1, rf_waddr=latched dstM and rf_wdata=latched valM; the next state SHALL be IDLE.
REQ-022 When dstE equals dstM and is not RNONE, the E write SHALL be dropped and only the M write issued, so the M value wins (popq %rsp rule).
REQ-023 In IDLE, rf_we SHALL be 0, with rf_waddr and rf_wdata held at their previous values.
REQ-024 wb_done SHALL pulse in the last write cycle (WR_M, or WR_E when no M write follows), or in the cycle after accept if both destinations are RNONE.
REQ-025 Latency SHALL be: first write in cycle accept+1; second write, if any, in cycle accept+2; there is no back-to-back accept, and the next accept occurs no earlier than the cycle after the last write.
REQ-026 pend_mask bits for the non-RNONE destinations in range SHALL be set on accept; each bit SHALL clear on the edge ending its write cycle; a dropped E write (REQ-022) SHALL set no separate bit.
REQ-027 Destination IDs in the range NREG..14 SHALL be treated as RNONE: no write is issued and no pend_mask bit is set.
REQ-028 wr_count SHALL increment by 1 on each cycle with rf_we=1 and saturate at 16'hFFFF.
REQ-029 wb_valid while wb_ready=0 SHALL be ignored, and the requester SHALL hold the request until it is accepted.

Reset
REQ-030 While rst_n=0, asynchronously: state=IDLE, rf_we=0, rf_waddr=0, rf_wdata=0, pend_mask=0, wb_done=0, wr_count=0; wb_ready SHALL read 1 after reset release.
REQ-031 Reset asserted mid-operation SHALL discard all pending writes; no rf_we SHALL be issued for the discarded request after release.

Verification
REQ-032 OPq: dstE=3, valE=0x55, dstM=F -> accept at T; T+1 rf_we=1, addr 3, data 0x55, wb_done=1; pend_mask bit 3 high only during T+1.
REQ-033 mrmovq then pop: dstE=4, valE=0x100, dstM=7, valM=0xAB -> T+1 write 4/0x100, T+2 write 7/0xAB with wb_done; wb_ready=0 in T+1 and T+2.
REQ-034 popq %rsp: dstE=4, valE=0x108, dstM=4, valM=0x99 -> single write at T+1 of addr 4/0x99; wr_count +1.
REQ-035 nop: dstE=F, dstM=F -> no rf_we; wb_done at T+1; pend_mask stays 0.
REQ-036 Reset mid-op: rst_n low during the WR_E cycle of REQ-033 -> rf_we drops immediately; no write of addr 7 after release; pend_mask=0.
REQ-037 Saturation: preload 0xFFFE writes, then issue 3 writes -> wr_count ends at 0xFFFF.

Source files
------------

// File: rtl/regfile_wb_sched_if.sv
// Write-back scheduler bus.
// Groups the request side (wb_valid/wb_ready plus the two destination/value
// pairs) with the register-file write port and the status outputs.
//   slave  : the scheduler (consumes requests, drives the rf write port)
//   master : the write-back stage / environment
interface regfile_wb_sched_if #(
  parameter int DW   = 64,
  parameter int NREG = 15
);
  logic            wb_valid;
  logic            wb_ready;
  logic [3:0]      dstE;
  logic [DW-1:0]   valE;
  logic [3:0]      dstM;
  logic [DW-1:0]   valM;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic [NREG-1:0] pend_mask;
  logic            wb_done;
  logic [15:0]     wr_count;

  modport slave (
    input  wb_valid, dstE, valE, dstM, valM,
    output wb_ready, rf_we, rf_waddr, rf_wdata, pend_mask, wb_done, wr_count
  );

  modport master (
    output wb_valid, dstE, valE, dstM, valM,
    input  wb_ready, rf_we, rf_waddr, rf_wdata, pend_mask, wb_done, wr_count
  );
endinterface

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: serialises the (dstE,valE)/(dstM,valM) pair of one
// write-back request onto a single register-file write port.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : regfile_wb_sched_if.slave
//     wb_valid/wb_ready        request handshake (ready only when idle)
//     dstE/valE, dstM/valM     the two candidate writes
//     rf_we/rf_waddr/rf_wdata  register-file write port
//     pend_mask                accepted-but-not-yet-written registers
//     wb_done                  pulse when the request is retired
//     wr_count                 saturating count of issued writes
module regfile_wb_sched #(
  parameter int         DW    = 64,
  parameter int         NREG  = 15,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WR_E, WR_M} state_t;

  state_t          state, state_nxt;
  logic            accept;
  logic            e_wr, m_wr;
  logic            m_wr_q;
  logic [3:0]      dstm_q;
  logic [DW-1:0]   valm_q;
  logic            nop_done_q;
  logic            rf_we;
  logic [3:0]      waddr_q;
  logic [DW-1:0]   wdata_q;
  logic [NREG-1:0] pend_q, pend_nxt;
  logic [15:0]     cnt_q;

  // Out-of-range IDs behave exactly like RNONE.
  function automatic logic dst_ok(input logic [3:0] d);
    return (d != RNONE) && (int'(d) < NREG);
  endfunction

  assign accept = bus.wb_valid && (state == IDLE);
  // dstE == dstM: only the M write is issued so the memory value wins.
  assign e_wr   = dst_ok(bus.dstE) && (bus.dstE != bus.dstM);
  assign m_wr   = dst_ok(bus.dstM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = e_wr ? WR_E : (m_wr ? WR_M : IDLE);
      WR_E: state_nxt = m_wr_q ? WR_M : IDLE;
      WR_M: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign rf_we = (state != IDLE);

  // A request with no valid destination still retires, one cycle after accept.
  assign bus.wb_done  = (state == WR_M) || ((state == WR_E) && !m_wr_q) || nop_done_q;
  assign bus.wb_ready = (state == IDLE);
  assign bus.rf_we    = rf_we;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;
  assign bus.pend_mask = pend_q;
  assign bus.wr_count = cnt_q;

  always_comb begin
    pend_nxt = pend_q;
    for (int i = 0; i < NREG; i++) begin
      if (rf_we && (waddr_q == 4'(i)))         pend_nxt[i] = 1'b0;
      if (accept && e_wr && (bus.dstE == 4'(i))) pend_nxt[i] = 1'b1;
      if (accept && m_wr && (bus.dstM == 4'(i))) pend_nxt[i] = 1'b1;
    end
  end

  // Write address/data are loaded on the edge entering each write state and
  // otherwise hold, so the port keeps its last value while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr_q     <= 1'b0;
      dstm_q     <= '0;
      valm_q     <= '0;
      nop_done_q <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pend_q     <= '0;
      cnt_q      <= '0;
    end else begin
      nop_done_q <= accept && !e_wr && !m_wr;
      pend_q     <= pend_nxt;
      if (rf_we && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
      if (accept) begin
        m_wr_q <= m_wr;
        dstm_q <= bus.dstM;
        valm_q <= bus.valM;
        if (e_wr) begin
          waddr_q <= bus.dstE;
          wdata_q <= bus.valE;
        end else if (m_wr) begin
          waddr_q <= bus.dstM;
          wdata_q <= bus.valM;
        end
      end else if ((state == WR_E) && m_wr_q) begin
        waddr_q <= dstm_q;
        wdata_q <= valm_q;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
  localparam int DW   = 64;
  localparam int NREG = 12;  // leaves IDs 12..14 out of range

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   mcnt  = 0;   // model of wr_count

  regfile_wb_sched_if #(.DW(DW), .NREG(NREG)) rif ();

  regfile_wb_sched #(.DW(DW), .NREG(NREG), .RNONE(4'hF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (rif.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  de;
    logic [63:0] ve;
    logic [3:0]  dm;
    logic [63:0] vm;
    int          n;
    logic [3:0]  a0;
    logic [63:0] d0;
    logic [3:0]  a1;
    logic [63:0] d1;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [NREG-1:0] bitof(input logic [3:0] a);
    logic [NREG-1:0] m;
    m = '0;
    if (int'(a) < NREG) m[a] = 1'b1;
    return m;
  endfunction

  // Reference: list the writes one request must produce.
  task automatic model(input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm,
                       output int n, output logic [3:0] a0, output logic [63:0] d0,
                       output logic [3:0] a1, output logic [63:0] d1);
    logic [3:0]  aq[$];
    logic [63:0] dq[$];
    if (int'(de) < NREG && de != dm) begin aq.push_back(de); dq.push_back(ve); end
    if (int'(dm) < NREG)             begin aq.push_back(dm); dq.push_back(vm); end
    n = aq.size();
    a0 = (n > 0) ? aq[0] : 4'h0;  d0 = (n > 0) ? dq[0] : 64'h0;
    a1 = (n > 1) ? aq[1] : 4'h0;  d1 = (n > 1) ? dq[1] : 64'h0;
  endtask

  // Present a request, wait (bounded) for accept, then check every cycle of
  // its retirement. Called at #1 after a rising edge; returns likewise.
  task automatic run_req(input string tag, input vec_t v);
    logic [3:0]      a[2];
    logic [63:0]     d[2];
    logic [NREG-1:0] pend;
    int w;
    a[0] = v.a0; a[1] = v.a1; d[0] = v.d0; d[1] = v.d1;
    rif.dstE = v.de; rif.valE = v.ve; rif.dstM = v.dm; rif.valM = v.vm;
    rif.wb_valid = 1'b1;
    w = 0;
    while (!rif.wb_ready && w < 8) begin step(); w++; end
    if (!rif.wb_ready) begin
      chk({tag, " accept_timeout"}, 64'(rif.wb_ready), 64'h1);
      rif.wb_valid = 1'b0;
      return;
    end
    step();
    rif.wb_valid = 1'b0;
    if (v.n == 0) begin
      chk({tag, " nop_we"},    64'(rif.rf_we), 64'h0);
      chk({tag, " nop_done"},  64'(rif.wb_done), 64'h1);
      chk({tag, " nop_pend"},  64'(rif.pend_mask), 64'h0);
      chk({tag, " nop_ready"}, 64'(rif.wb_ready), 64'h1);
      return;
    end
    for (int k = 0; k < v.n; k++) begin
      pend = '0;
      for (int j = k; j < v.n; j++) pend |= bitof(a[j]);
      chk($sformatf("%s c%0d we", tag, k),    64'(rif.rf_we), 64'h1);
      chk($sformatf("%s c%0d addr", tag, k),  64'(rif.rf_waddr), 64'(a[k]));
      chk($sformatf("%s c%0d data", tag, k),  rif.rf_wdata, d[k]);
      chk($sformatf("%s c%0d done", tag, k),  64'(rif.wb_done), 64'(k == v.n - 1));
      chk($sformatf("%s c%0d pend", tag, k),  64'(rif.pend_mask), 64'(pend));
      chk($sformatf("%s c%0d ready", tag, k), 64'(rif.wb_ready), 64'h0);
      step();
      mcnt = (mcnt >= 16'hFFFF) ? 16'hFFFF : mcnt + 1;
    end
    chk({tag, " idle_we"},    64'(rif.rf_we), 64'h0);
    chk({tag, " idle_done"},  64'(rif.wb_done), 64'h0);
    chk({tag, " idle_pend"},  64'(rif.pend_mask), 64'h0);
    chk({tag, " idle_ready"}, 64'(rif.wb_ready), 64'h1);
    chk({tag, " hold_addr"},  64'(rif.rf_waddr), 64'(a[v.n-1]));
    chk({tag, " hold_data"},  rif.rf_wdata, d[v.n-1]);
    chk({tag, " count"},      64'(rif.wr_count), 64'(mcnt));
  endtask

  vec_t tbl[9];
  vec_t v;

  initial begin
    rif.wb_valid = 1'b0;
    rif.dstE = 4'hF; rif.valE = '0; rif.dstM = 4'hF; rif.valM = '0;

    // Reset values
    #2;
    chk("rst_we",    64'(rif.rf_we), 64'h0);
    chk("rst_addr",  64'(rif.rf_waddr), 64'h0);
    chk("rst_data",  rif.rf_wdata, 64'h0);
    chk("rst_pend",  64'(rif.pend_mask), 64'h0);
    chk("rst_done",  64'(rif.wb_done), 64'h0);
    chk("rst_count", 64'(rif.wr_count), 64'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", 64'(rif.wb_ready), 64'h1);

    //           de    ve           dm    vm           n  a0    d0           a1    d1
    tbl[0] = '{4'h3, 64'h55,     4'hF, 64'h0,      1, 4'h3, 64'h55,     4'h0, 64'h0};
    tbl[1] = '{4'h4, 64'h100,    4'h7, 64'hAB,     2, 4'h4, 64'h100,    4'h7, 64'hAB};
    tbl[2] = '{4'h4, 64'h108,    4'h4, 64'h99,     1, 4'h4, 64'h99,     4'h0, 64'h0};
    tbl[3] = '{4'hF, 64'h12,     4'hF, 64'h34,     0, 4'h0, 64'h0,      4'h0, 64'h0};
    tbl[4] = '{4'hD, 64'h11,     4'h5, 64'h22,     1, 4'h5, 64'h22,     4'h0, 64'h0};
    tbl[5] = '{4'h2, 64'h33,     4'hE, 64'h44,     1, 4'h2, 64'h33,     4'h0, 64'h0};
    tbl[6] = '{4'hC, 64'h1,      4'hC, 64'h2,      0, 4'h0, 64'h0,      4'h0, 64'h0};
    tbl[7] = '{4'h0, 64'hDEAD,   4'hB, 64'hBEEF,   2, 4'h0, 64'hDEAD,   4'hB, 64'hBEEF};
    tbl[8] = '{4'hF, 64'h1,      4'h9, 64'h77,     1, 4'h9, 64'h77,     4'h0, 64'h0};
    for (int i = 0; i < 9; i++) run_req($sformatf("vec%0d", i), tbl[i]);

    // Request held while busy: B must wait until A has fully retired.
    v = '{4'h1, 64'hA1, 4'h2, 64'hA2, 2, 4'h1, 64'hA1, 4'h2, 64'hA2};
    rif.dstE = v.de; rif.valE = v.ve; rif.dstM = v.dm; rif.valM = v.vm;
    rif.wb_valid = 1'b1;
    step();
    rif.dstE = 4'h5; rif.valE = 64'hB5; rif.dstM = 4'hF; rif.valM = 64'h0;
    chk("hold_c1_addr", 64'(rif.rf_waddr), 64'h1);
    chk("hold_c1_data", rif.rf_wdata, 64'hA1);
    step();
    chk("hold_c2_addr", 64'(rif.rf_waddr), 64'h2);
    chk("hold_c2_data", rif.rf_wdata, 64'hA2);
    chk("hold_c2_ready", 64'(rif.wb_ready), 64'h0);
    step();
    chk("hold_c3_we", 64'(rif.rf_we), 64'h0);
    chk("hold_c3_ready", 64'(rif.wb_ready), 64'h1);
    step();
    rif.wb_valid = 1'b0;
    chk("hold_c4_we", 64'(rif.rf_we), 64'h1);
    chk("hold_c4_addr", 64'(rif.rf_waddr), 64'h5);
    chk("hold_c4_data", rif.rf_wdata, 64'hB5);
    step();
    mcnt += 3;
    chk("hold_count", 64'(rif.wr_count), 64'(mcnt));

    // Randomized requests against the model
    for (int i = 0; i < 200; i++) begin
      v.de = 4'($urandom_range(0, 15));
      v.dm = ($urandom_range(0, 3) == 0) ? v.de : 4'($urandom_range(0, 15));
      v.ve = {$urandom, $urandom};
      v.vm = {$urandom, $urandom};
      model(v.de, v.ve, v.dm, v.vm, v.n, v.a0, v.d0, v.a1, v.d1);
      run_req($sformatf("rnd%0d", i), v);
    end

    // Reset during the first write of a two-write request
    rif.dstE = 4'h4; rif.valE = 64'h100; rif.dstM = 4'h7; rif.valM = 64'hAB;
    rif.wb_valid = 1'b1;
    step();
    rif.wb_valid = 1'b0;
    chk("mid_we_before", 64'(rif.rf_we), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_we",    64'(rif.rf_we), 64'h0);
    chk("mid_pend",  64'(rif.pend_mask), 64'h0);
    chk("mid_addr",  64'(rif.rf_waddr), 64'h0);
    chk("mid_count", 64'(rif.wr_count), 64'h0);
    step();
    rst_n = 1'b1;
    mcnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post_rst%0d_we", k),    64'(rif.rf_we), 64'h0);
      chk($sformatf("post_rst%0d_pend", k),  64'(rif.pend_mask), 64'h0);
      chk($sformatf("post_rst%0d_ready", k), 64'(rif.wb_ready), 64'h1);
    end

    // Saturation: preload the counter just below the top, then three writes
    dut.cnt_q = 16'hFFFE;
    mcnt = 16'hFFFE;
    run_req("sat_a", '{4'h4, 64'h1, 4'h7, 64'h2, 2, 4'h4, 64'h1, 4'h7, 64'h2});
    run_req("sat_b", '{4'h3, 64'h5, 4'hF, 64'h0, 1, 4'h3, 64'h5, 4'h0, 64'h0});
    chk("sat_final", 64'(rif.wr_count), 64'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
